// File: rtl/ex_mem_buf_pkg.sv
// Shared constants and control encodings for the EX/MEM elastic buffer.
// Latency: n/a (declarations only). Backpressure: n/a.
package ex_mem_buf_pkg;

    localparam int RegBus        = 32;
    localparam int RegAddrBus    = 5;
    localparam int ExMemPerfCntW = 32;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_op_e;

    typedef enum logic {
        SRC_INPUT = 1'b0,
        SRC_SKID  = 1'b1
    } out_src_e;

    // Saturating increment used by the optional stall counter.
    function automatic logic [ExMemPerfCntW-1:0] sat_inc(input logic [ExMemPerfCntW-1:0] v);
        return (v == '1) ? v : v + ExMemPerfCntW'(1);
    endfunction

endpackage

// File: rtl/ex_mem_buf_pipe_slot.sv
// One pipeline slot: valid bit plus payload register with load/clear.
// Latency: 1 cycle from load to q. Backpressure: none, the owner decides when to load.
module ex_mem_buf_pipe_slot
    import ex_mem_buf_pkg::*;
#(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  slot_op_e     op,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Clear drops only the valid bit; the payload is left as-is.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            case (op)
                SLOT_LOAD: begin
                    valid <= 1'b1;
                    q     <= d;
                end
                SLOT_CLEAR: valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_buf.sv
// EX->MEM elastic register: output slot plus skid slot, registered ready_o, sync flush.
// Latency 1 cycle when empty, 1 entry/cycle; ready_o = ~skid_valid. Optional EX_MEM_BUF_PERF_EN adds stall_cnt_o.
module ex_mem_buf
    import ex_mem_buf_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o
`ifdef EX_MEM_BUF_PERF_EN
    ,
    output logic [ExMemPerfCntW-1:0] stall_cnt_o
`endif
);

    localparam int PW = DATA_W + ADDR_W + 1;

    logic          ov;
    logic          sv;
    logic [PW-1:0] out_q;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_pay;
    logic [PW-1:0] out_d;
    slot_op_e      out_op;
    slot_op_e      skid_op;
    out_src_e      out_src;
    logic          acc;
    logic          fire;

    assign in_pay = {wdata_i, wd_i, wreg_i};
    assign ready_o = ~sv;
    assign valid_o = ov;
    assign acc     = valid_i & ready_o;
    assign fire    = ov & ready_i;

    // Skid drains into out before any new input; acc cannot coincide since ready_o=0.
    always_comb begin
        out_op  = SLOT_HOLD;
        skid_op = SLOT_HOLD;
        out_src = SRC_INPUT;
        if (flush_i) begin
            out_op  = SLOT_CLEAR;
            skid_op = SLOT_CLEAR;
        end else if (!ov || fire) begin
            if (sv) begin
                out_op  = SLOT_LOAD;
                out_src = SRC_SKID;
                skid_op = SLOT_CLEAR;
            end else if (acc) begin
                out_op = SLOT_LOAD;
            end else begin
                out_op = SLOT_CLEAR;
            end
        end else if (acc) begin
            skid_op = SLOT_LOAD;
        end
    end

    assign out_d = (out_src == SRC_SKID) ? skid_q : in_pay;

    ex_mem_buf_pipe_slot #(.W(PW)) u_out (
        .clk   (clk),
        .rst   (rst),
        .op    (out_op),
        .d     (out_d),
        .valid (ov),
        .q     (out_q)
    );

    ex_mem_buf_pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .op    (skid_op),
        .d     (in_pay),
        .valid (sv),
        .q     (skid_q)
    );

    assign wdata_o = out_q[PW-1 -: DATA_W];
    assign wd_o    = out_q[ADDR_W:1];
    assign wreg_o  = out_q[0] & ov;

`ifdef EX_MEM_BUF_PERF_EN
    logic [ExMemPerfCntW-1:0] stall_cnt_q;

    // Flush deliberately does not clear the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (ov && !ready_i) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_buf.sv
// Bench for ex_mem_buf: directed scenarios plus randomized traffic against a queue model.
module tb_ex_mem_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] wdata_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
`ifdef EX_MEM_BUF_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [37:0] q[$];
    logic [31:0] exp_stall = '0;

    always #5 clk = ~clk;

    ex_mem_buf dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .wdata_i (wdata_i),
        .wd_i    (wd_i),
        .wreg_i  (wreg_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .wdata_o (wdata_o),
        .wd_o    (wd_o),
        .wreg_o  (wreg_o)
`ifdef EX_MEM_BUF_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // Model: the buffer is a 2-deep FIFO; it accepts whenever it holds fewer than two.
    task automatic step();
        logic acc;
        logic fire;
        @(negedge clk);
        acc  = valid_i && (q.size() < 2);
        fire = (q.size() > 0) && ready_i;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            exp_stall = '0;
        end else begin
            if (q.size() > 0 && !ready_i && exp_stall != 32'hFFFF_FFFF)
                exp_stall = exp_stall + 32'd1;
            if (flush_i) begin
                q.delete();
            end else begin
                if (fire) void'(q.pop_front());
                if (acc) q.push_back({wdata_i, wd_i, wreg_i});
            end
        end
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] a, input logic w);
        valid_i = 1'b1;
        wdata_i = d;
        wd_i    = a;
        wreg_i  = w;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        push($urandom, 5'($urandom), 1'b1);
        step();
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready_o); end
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL reset_wreg got %0b want 0", wreg_o); end
        checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
        checks++; if (wd_o !== 5'h0) begin errors++; $display("FAIL reset_wd got %h want 0", wd_o); end
        rst = 1'b1; valid_i = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(32'(i), 5'd3, 1'b1);
            step();
            checks++; if (valid_o !== 1'b1 || wdata_o !== 32'(i)) begin
                errors++; $display("FAIL stream_data got v=%0b d=%0d want v=1 d=%0d", valid_o, wdata_o, i);
            end
            checks++; if (wd_o !== 5'd3 || wreg_o !== 1'b1) begin
                errors++; $display("FAIL stream_dest got wd=%0d wreg=%0b want wd=3 wreg=1", wd_o, wreg_o);
            end
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready got %0b want 1", ready_o); end
        end
        valid_i = 1'b0;
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", valid_o); end
    endtask

    task automatic test_back_pressure();
        ready_i = 1'b0;
        push(32'hAAAA0001, 5'd1, 1'b1);
        step();
        checks++; if (valid_o !== 1'b1 || wdata_o !== 32'hAAAA0001 || ready_o !== 1'b1) begin
            errors++; $display("FAIL bp_first got v=%0b d=%h r=%0b want v=1 d=aaaa0001 r=1", valid_o, wdata_o, ready_o);
        end
        push(32'hBBBB0002, 5'd2, 1'b1);
        step();
        valid_i = 1'b0;
        checks++; if (ready_o !== 1'b0 || wdata_o !== 32'hAAAA0001) begin
            errors++; $display("FAIL bp_full got r=%0b d=%h want r=0 d=aaaa0001", ready_o, wdata_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (valid_o !== 1'b1 || wdata_o !== 32'hAAAA0001 || wd_o !== 5'd1 || ready_o !== 1'b0) begin
                errors++; $display("FAIL bp_stable got v=%0b d=%h wd=%0d r=%0b want v=1 d=aaaa0001 wd=1 r=0", valid_o, wdata_o, wd_o, ready_o);
            end
        end
        ready_i = 1'b1;
        step();
        checks++; if (valid_o !== 1'b1 || wdata_o !== 32'hBBBB0002 || ready_o !== 1'b1) begin
            errors++; $display("FAIL bp_release got v=%0b d=%h r=%0b want v=1 d=bbbb0002 r=1", valid_o, wdata_o, ready_o);
        end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b want 0", valid_o); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        push(32'hAAAA0001, 5'd1, 1'b1);
        step();
        push(32'hBBBB0002, 5'd2, 1'b1);
        step();
        flush_i = 1'b1; ready_i = 1'b1;
        push(32'hCCCC0003, 5'd3, 1'b1);
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || wreg_o !== 1'b0) begin
            errors++; $display("FAIL flush_state got v=%0b r=%0b wreg=%0b want v=0 r=1 wreg=0", valid_o, ready_o, wreg_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_leak got v=%0b d=%h want v=0", valid_o, wdata_o); end
        end
    endtask

    task automatic test_reset_mid_stall();
        ready_i = 1'b0;
        push(32'h1111_0001, 5'd4, 1'b1);
        step();
        push(32'h2222_0002, 5'd5, 1'b1);
        step();
        checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
            errors++; $display("FAIL rms_full got r=%0b v=%0b want r=0 v=1", ready_o, valid_o);
        end
        rst = 1'b0; flush_i = 1'b1;
        step();
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || wdata_o !== 32'h0 || wd_o !== 5'h0 || wreg_o !== 1'b0) begin
            errors++; $display("FAIL rms_reset got v=%0b r=%0b d=%h wd=%0d wreg=%0b want 0 1 0 0 0", valid_o, ready_o, wdata_o, wd_o, wreg_o);
        end
        ready_i = 1'b1;
        push(32'h3333_0003, 5'd6, 1'b0);
        step();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || wdata_o !== 32'h3333_0003 || wd_o !== 5'd6 || wreg_o !== 1'b0) begin
            errors++; $display("FAIL rms_push got v=%0b d=%h wd=%0d wreg=%0b want 1 33330003 6 0", valid_o, wdata_o, wd_o, wreg_o);
        end
        step();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rms_drain got %0b want 0", valid_o); end
    endtask

    task automatic test_random();
        int fires;
        fires = 0;
        for (int i = 0; i < 400; i++) begin
            flush_i = ($urandom_range(0, 15) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) push($urandom, 5'($urandom), 1'($urandom));
            else valid_i = 1'b0;
            step();
            checks++; if (valid_o !== (q.size() > 0)) begin
                errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, valid_o, q.size() > 0);
            end
            checks++; if (ready_o !== (q.size() < 2)) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %0b want %0b", i, ready_o, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++; if ({wdata_o, wd_o, wreg_o} !== q[0]) begin
                    errors++; $display("FAIL rnd_head cyc %0d got %h want %h", i, {wdata_o, wd_o, wreg_o}, q[0]);
                end
                if (ready_i) fires++;
            end else begin
                checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL rnd_wreg_idle cyc %0d got %0b want 0", i, wreg_o); end
            end
`ifdef EX_MEM_BUF_PERF_EN
            checks++; if (stall_cnt_o !== exp_stall) begin
                errors++; $display("FAIL rnd_stall cyc %0d got %0d want %0d", i, stall_cnt_o, exp_stall);
            end
`endif
        end
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (fires < 50) begin errors++; $display("FAIL rnd_activity got %0d fires want >=50", fires); end
    endtask

`ifdef EX_MEM_BUF_PERF_EN
    task automatic test_perf();
        rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        step();
        rst = 1'b1;
        checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL perf_reset got %0d want 0", stall_cnt_o); end
        ready_i = 1'b0;
        push(32'h5555_0005, 5'd7, 1'b1);
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (stall_cnt_o !== 32'd5) begin errors++; $display("FAIL perf_count got %0d want 5", stall_cnt_o); end
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        exp_stall = 32'hFFFF_FFFF;
        step();
        checks++; if (stall_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL perf_sat got %h want ffffffff", stall_cnt_o); end
        ready_i = 1'b1;
        step();
    endtask
`endif

    initial begin
        rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        wdata_i = '0; wd_i = '0; wreg_i = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_reset_mid_stall();
        test_random();
`ifdef EX_MEM_BUF_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
